// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 width codes,
// RAM enable encodings, the controller state type and small decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EN_NONE = 2'b00;
  localparam logic [1:0] EN_BYTE = 2'b01;
  localparam logic [1:0] EN_HALF = 2'b10;
  localparam logic [1:0] EN_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } lsu_state_e;

  // Stores only know B/H/W; loads additionally accept the unsigned forms.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) begin
      return !(f3 inside {F3_B, F3_H, F3_W});
    end
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  // funct3[1:0] carries the access size for every legal code.
  function automatic logic [1:0] f3_enable(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return EN_BYTE;
      2'b01:   return EN_HALF;
      2'b10:   return EN_WORD;
      default: return EN_NONE;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
    case (f3[1:0])
      2'b01:   return lsb[0];
      2'b10:   return lsb != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational width/sign extension of right-aligned RAM read data.
// Ports:
//   funct3 - RV32 load width code
//   data   - raw RAM read data, right-aligned
//   ext    - extended result
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] data,
  output logic [31:0] ext
);

  always_comb begin
    ext = data;
    case (funct3)
      F3_B:    ext = {{24{data[7]}}, data[7:0]};
      F3_H:    ext = {{16{data[15]}}, data[15:0]};
      F3_BU:   ext = {24'h0, data[7:0]};
      F3_HU:   ext = {16'h0, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store unit between the execute stage and the RAM data port.
// One request in flight: IDLE accepts, ISSUE strobes the RAM for one cycle
// (or idles for a faulted request), RESP holds the response until consumed.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   req_valid/req_ready             - request handshake
//   req_we, req_funct3, req_addr,
//   req_wdata                       - request payload
//   resp_valid/resp_ready           - response handshake
//   resp_rdata, resp_err            - response payload
//   mem_addr, mem_write_en,
//   mem_read_en, mem_wdata          - RAM data port drive (all registered)
//   mem_rdata                       - RAM combinational read data
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_MSB = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_write_en,
  output logic [1:0]  mem_read_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state, state_nxt;

  logic        lat_we, lat_we_nxt;
  logic [2:0]  lat_f3, lat_f3_nxt;
  logic        lat_fault, lat_fault_nxt;

  logic        req_ready_nxt;
  logic        resp_valid_nxt;
  logic [31:0] resp_rdata_nxt;
  logic        resp_err_nxt;
  logic [31:0] mem_addr_nxt;
  logic [1:0]  mem_write_en_nxt;
  logic [1:0]  mem_read_en_nxt;
  logic [31:0] mem_wdata_nxt;

  logic        req_fault;
  logic [31:0] ext_data;

  // Priority order only matters for reporting; any hit suppresses the access.
  assign req_fault = f3_illegal(req_we, req_funct3)
                   || ((req_addr >> (ADDR_MSB + 1)) != '0)
                   || f3_misaligned(req_funct3, req_addr[1:0]);

  lsu_load_ext u_load_ext (
    .funct3 (lat_f3),
    .data   (mem_rdata),
    .ext    (ext_data)
  );

  // State and every output are registered together so a reset mid-ISSUE
  // drops the strobes asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lat_we       <= 1'b0;
      lat_f3       <= '0;
      lat_fault    <= 1'b0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      mem_addr     <= '0;
      mem_write_en <= EN_NONE;
      mem_read_en  <= EN_NONE;
      mem_wdata    <= '0;
    end else begin
      state        <= state_nxt;
      lat_we       <= lat_we_nxt;
      lat_f3       <= lat_f3_nxt;
      lat_fault    <= lat_fault_nxt;
      req_ready    <= req_ready_nxt;
      resp_valid   <= resp_valid_nxt;
      resp_rdata   <= resp_rdata_nxt;
      resp_err     <= resp_err_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_write_en <= mem_write_en_nxt;
      mem_read_en  <= mem_read_en_nxt;
      mem_wdata    <= mem_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Computes the value each registered output takes at the next edge.
  // Enables default to none, so they are only high for the ISSUE cycle.
  always_comb begin
    lat_we_nxt       = lat_we;
    lat_f3_nxt       = lat_f3;
    lat_fault_nxt    = lat_fault;
    req_ready_nxt    = req_ready;
    resp_valid_nxt   = resp_valid;
    resp_rdata_nxt   = resp_rdata;
    resp_err_nxt     = resp_err;
    mem_addr_nxt     = mem_addr;
    mem_wdata_nxt    = mem_wdata;
    mem_write_en_nxt = EN_NONE;
    mem_read_en_nxt  = EN_NONE;
    case (state)
      IDLE: begin
        req_ready_nxt = 1'b1;
        if (req_valid) begin
          req_ready_nxt = 1'b0;
          lat_we_nxt    = req_we;
          lat_f3_nxt    = req_funct3;
          lat_fault_nxt = req_fault;
          if (!req_fault) begin
            mem_addr_nxt  = req_addr;
            mem_wdata_nxt = req_we ? req_wdata : '0;
            if (req_we) mem_write_en_nxt = f3_enable(req_funct3);
            else        mem_read_en_nxt  = f3_enable(req_funct3);
          end
        end
      end
      ISSUE: begin
        resp_valid_nxt = 1'b1;
        resp_err_nxt   = lat_fault;
        resp_rdata_nxt = (lat_fault || lat_we) ? '0 : ext_data;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_nxt = 1'b0;
          resp_err_nxt   = 1'b0;
          req_ready_nxt  = 1'b1;
        end
      end
      default: begin
        req_ready_nxt  = 1'b1;
        resp_valid_nxt = 1'b0;
        resp_err_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: a behavioural RAM drives the
// data port, and a byte-array reference model predicts every response.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [1:0]  mem_write_en;
  logic [1:0]  mem_read_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  logic [7:0] ram     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] ra;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.ADDR_MSB(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Behavioural RAM: little-endian, lane from the low address bits,
  // combinational zero-extended read, write at the rising edge.
  assign ra = mem_addr[7:0];

  always_comb begin
    mem_rdata = '0;
    case (mem_read_en)
      2'b01:   mem_rdata = {24'h0, ram[ra]};
      2'b10:   mem_rdata = {16'h0, ram[ra + 8'd1], ram[ra]};
      2'b11:   mem_rdata = {ram[ra + 8'd3], ram[ra + 8'd2], ram[ra + 8'd1], ram[ra]};
      default: mem_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    case (mem_write_en)
      2'b01: ram[ra] <= mem_wdata[7:0];
      2'b10: begin
        ram[ra]        <= mem_wdata[7:0];
        ram[ra + 8'd1] <= mem_wdata[15:8];
      end
      2'b11: begin
        ram[ra]        <= mem_wdata[7:0];
        ram[ra + 8'd1] <= mem_wdata[15:8];
        ram[ra + 8'd2] <= mem_wdata[23:16];
        ram[ra + 8'd3] <= mem_wdata[31:24];
      end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: decides fault, enable code and result from the
  // architectural rules, updating its own byte image for stores.
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic flt, output logic [1:0] en,
                              output logic [31:0] rd);
    int unsigned nb;
    logic [31:0] raw;
    logic        illegal, oor, mis;
    if (we) illegal = (f3 > 3'd2);
    else    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    oor = (addr >= 32'h0001_0000);
    mis = ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) || (f3 == 3'd2 && (addr % 4 != 0));
    flt = illegal || oor || mis;
    nb  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    en  = flt ? 2'd0 : (nb == 1) ? 2'd1 : (nb == 2) ? 2'd2 : 2'd3;
    rd  = '0;
    if (flt) return;
    if (we) begin
      for (int unsigned i = 0; i < nb; i++)
        ref_mem[(addr + i) % 256] = 8'((wd >> (8 * i)) % 256);
      return;
    end
    raw = 0;
    for (int unsigned i = 0; i < nb; i++)
      raw = raw + (32'(ref_mem[(addr + i) % 256]) << (8 * i));
    if (f3 == 3'd0 && raw >= 32'd128)   rd = raw + 32'hFFFF_FF00;
    else if (f3 == 3'd1 && raw >= 32'd32768) rd = raw + 32'hFFFF_0000;
    else rd = raw;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int unsigned stall);
    logic        flt;
    logic [1:0]  en;
    logic [31:0] rd;
    model_access(we, f3, addr, wd, flt, en, rd);
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr  = $urandom;
    check_eq("issue_write_en", 32'(mem_write_en), we ? 32'(en) : 32'd0);
    check_eq("issue_read_en", 32'(mem_read_en), we ? 32'd0 : 32'(en));
    check_eq("issue_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("issue_req_ready", 32'(req_ready), 32'd0);
    if (!flt) begin
      check_eq("issue_mem_addr", mem_addr, addr);
      check_eq("issue_mem_wdata", mem_wdata, we ? wd : 32'd0);
    end
    @(negedge clk);
    check_eq("resp_valid", 32'(resp_valid), 32'd1);
    check_eq("resp_err", 32'(resp_err), 32'(flt));
    check_eq("resp_rdata", resp_rdata, rd);
    check_eq("resp_enables", {28'h0, mem_write_en, mem_read_en}, 32'd0);
    for (int unsigned s = 0; s < stall; s++) begin
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'd2;
      req_addr   = 32'h20;
      @(negedge clk);
      check_eq("stall_resp_valid", 32'(resp_valid), 32'd1);
      check_eq("stall_resp_rdata", resp_rdata, rd);
      check_eq("stall_resp_err", 32'(resp_err), 32'(flt));
      check_eq("stall_req_ready", 32'(req_ready), 32'd0);
      check_eq("stall_enables", {28'h0, mem_write_en, mem_read_en}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq("done_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("done_resp_err", 32'(resp_err), 32'd0);
    check_eq("done_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic reset_mid_issue();
    check_eq("rst_req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rst_issue_read_en", 32'(mem_read_en), 32'd3);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_read_en", 32'(mem_read_en), 32'd0);
    check_eq("rst_async_write_en", 32'(mem_write_en), 32'd0);
    check_eq("rst_async_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_async_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_after_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_after_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [2:0]  lf [5];
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int unsigned i = 0; i < 256; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_req_ready", 32'(req_ready), 32'd1);
    check_eq("reset_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("reset_resp_err", 32'(resp_err), 32'd0);
    check_eq("reset_resp_rdata", resp_rdata, 32'd0);
    check_eq("reset_enables", {28'h0, mem_write_en, mem_read_en}, 32'd0);
    check_eq("reset_mem_addr", mem_addr, 32'd0);
    check_eq("reset_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0);
    do_req(1'b1, 3'd0, 32'h13, 32'h0000_0080, 0);
    do_req(1'b0, 3'd0, 32'h13, 32'h0, 0);
    do_req(1'b0, 3'd4, 32'h13, 32'h0, 0);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0);
    do_req(1'b1, 3'd1, 32'h16, 32'h0000_8001, 0);
    do_req(1'b0, 3'd1, 32'h16, 32'h0, 0);
    do_req(1'b0, 3'd5, 32'h16, 32'h0, 0);
    do_req(1'b0, 3'd2, 32'h12, 32'h0, 0);
    do_req(1'b1, 3'd1, 32'h11, 32'h1234_5678, 0);
    do_req(1'b0, 3'd0, 32'h0001_0000, 32'h0, 0);
    do_req(1'b0, 3'd3, 32'h10, 32'h0, 0);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 5);
    do_req(1'b0, 3'd5, 32'h16, 32'h0, 0);
    reset_mid_issue();
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0);

    for (int unsigned i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
      else if (we)                   f3 = lf[$urandom_range(0, 2)];
      else                           f3 = lf[$urandom_range(0, 4)];
      if ($urandom_range(0, 15) == 0) addr = 32'h1 << $urandom_range(16, 31);
      else                            addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) addr = addr & ~32'h1;
        if (f3[1:0] == 2'b10) addr = addr & ~32'h3;
      end
      do_req(we, f3, addr, $urandom, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
